// File: rtl/gobang_pkg.sv
// Shared encodings for the gobang board engine: commands, results, FSM states
// and the four scan directions used by the win check.
package gobang_pkg;

  typedef enum logic [2:0] {
    CMD_UP      = 3'd0,
    CMD_DOWN    = 3'd1,
    CMD_LEFT    = 3'd2,
    CMD_RIGHT   = 3'd3,
    CMD_PLACE   = 3'd4,
    CMD_RESTART = 3'd5,
    CMD_NOP     = 3'd6
  } cmd_e;

  localparam logic [1:0] WINNER_NONE  = 2'b00;
  localparam logic [1:0] WINNER_BLACK = 2'b01;
  localparam logic [1:0] WINNER_WHITE = 2'b10;
  localparam logic [1:0] WINNER_DRAW  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_END
  } state_e;

  // Directions scanned in order: horizontal, vertical, diagonal, anti-diagonal.
  localparam int NUM_DIRS = 4;
  localparam logic signed [1:0] DIR_DR [NUM_DIRS] = '{2'sd0, 2'sd1, 2'sd1,  2'sd1};
  localparam logic signed [1:0] DIR_DC [NUM_DIRS] = '{2'sd1, 2'sd0, 2'sd1, -2'sd1};

endpackage

// File: rtl/gobang_board_ctrl_win_scan.sv
// Sequential five-in-a-row check: probes one cell per cycle around the last
// placed stone, walking each direction forward then backward.
module gobang_win_scan
  import gobang_pkg::*;
#(
  parameter int N   = 15,
  parameter int WIN = 5,
  parameter int RW  = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             en,
  input  logic [RW-1:0]    org_row,
  input  logic [RW-1:0]    org_col,
  input  logic             color,
  input  logic [N*N-1:0]   board_black,
  input  logic [N*N-1:0]   board_white,
  output logic             done,
  output logic             win
);

  localparam int KW = $clog2(WIN + 1);
  localparam int SW = RW + 2;
  localparam int CW = $clog2(N * N);
  localparam logic signed [SW-1:0] N_S = SW'(N);

  logic [1:0]           dir;
  logic                 leg;
  logic [KW-1:0]        k;
  logic [KW-1:0]        run;
  logic signed [1:0]    sr, sc;
  logic signed [SW-1:0] k_s, pr, pc;
  logic [CW-1:0]        idx;
  logic [N*N-1:0]       mover;
  logic                 on_board, hit, last_k, leg_end;

  function automatic logic signed [SW-1:0] scale(logic signed [1:0] s,
                                                 logic signed [SW-1:0] m);
    if (s == 2'sd1)  return m;
    if (s == -2'sd1) return -m;
    return '0;
  endfunction

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    sr       = leg ? -DIR_DR[dir] : DIR_DR[dir];
    sc       = leg ? -DIR_DC[dir] : DIR_DC[dir];
    k_s      = SW'(k);
    pr       = $signed(SW'(org_row)) + scale(sr, k_s);
    pc       = $signed(SW'(org_col)) + scale(sc, k_s);
    on_board = !pr[SW-1] && (pr < N_S) && !pc[SW-1] && (pc < N_S);
    idx      = CW'(pr[RW-1:0]) * CW'(N) + CW'(pc[RW-1:0]);
    mover    = color ? board_white : board_black;
    hit      = en && on_board && mover[idx];
    last_k   = (k == KW'(WIN - 1));
    leg_end  = !hit || last_k;
    win      = hit && (run == KW'(WIN - 1));
    done     = en && (win || (leg_end && leg && (dir == 2'd3)));
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir <= '0;
      leg <= 1'b0;
      k   <= '0;
      run <= '0;
    end else if (start) begin
      dir <= '0;
      leg <= 1'b0;
      k   <= KW'(1);
      run <= KW'(1);
    end else if (en) begin
      if (hit) run <= run + KW'(1);
      if (leg_end) begin
        k   <= KW'(1);
        leg <= ~leg;
        // Backward leg finished: next direction restarts with the origin stone only.
        if (leg) begin
          dir <= dir + 2'd1;
          run <= KW'(1);
        end
      end else begin
        k <= k + KW'(1);
      end
    end
  end

endmodule

// File: rtl/gobang_board_ctrl.sv
// Gobang board-state engine: owns both occupancy boards, the cursor and turn,
// applies decoded key commands and sequences the win/draw check.
module gobang_board_ctrl
  import gobang_pkg::*;
#(
  parameter int N    = 15,
  parameter int WIN  = 5,
  parameter int WRAP = 1,
  parameter int RW   = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [2:0]       cmd,
  output logic             cmd_ready,
  output logic [N*N-1:0]   display_black,
  output logic [N*N-1:0]   display_white,
  output logic [RW-1:0]    choose_row,
  output logic [RW-1:0]    choose_col,
  output logic             turn,
  output logic             busy,
  output logic             game_over,
  output logic [1:0]       winner
);

  localparam int CW = $clog2(N * N);
  localparam int MW = $clog2(N * N + 1);
  localparam logic [RW-1:0] MID  = RW'(N / 2);
  localparam logic [RW-1:0] EDGE = RW'(N - 1);

  state_e        state, state_next;
  logic [RW-1:0] org_row, org_col;
  logic [MW-1:0] move_cnt;
  logic [CW-1:0] cell_idx;
  logic          accept, occupied, board_full, start_scan, scan_done, scan_win;

  function automatic logic [RW-1:0] step_dec(logic [RW-1:0] v);
    if (v == '0) return (WRAP != 0) ? EDGE : '0;
    return v - RW'(1);
  endfunction

  function automatic logic [RW-1:0] step_inc(logic [RW-1:0] v);
    if (v == EDGE) return (WRAP != 0) ? '0 : EDGE;
    return v + RW'(1);
  endfunction

  // END still accepts commands so that RESTART can leave it.
  assign cmd_ready  = (state != S_CHECK);
  assign busy       = (state == S_CHECK);
  assign accept     = cmd_valid && cmd_ready;
  assign cell_idx   = CW'(choose_row) * CW'(N) + CW'(choose_col);
  assign occupied   = display_black[cell_idx] | display_white[cell_idx];
  assign board_full = (move_cnt == MW'(N * N));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    start_scan = 1'b0;
    case (state)
      S_IDLE:  if (accept && cmd == CMD_PLACE && !occupied) begin
                 state_next = S_CHECK;
                 start_scan = 1'b1;
               end
      S_CHECK: if (scan_done) state_next = (scan_win || board_full) ? S_END : S_IDLE;
      S_END:   if (accept && cmd == CMD_RESTART) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      display_black <= '0;
      display_white <= '0;
      choose_row    <= MID;
      choose_col    <= MID;
      turn          <= 1'b0;
      game_over     <= 1'b0;
      winner        <= WINNER_NONE;
      move_cnt      <= '0;
      org_row       <= MID;
      org_col       <= MID;
    end else if (accept && cmd == CMD_RESTART) begin
      display_black <= '0;
      display_white <= '0;
      choose_row    <= MID;
      choose_col    <= MID;
      turn          <= 1'b0;
      game_over     <= 1'b0;
      winner        <= WINNER_NONE;
      move_cnt      <= '0;
      org_row       <= MID;
      org_col       <= MID;
    end else if (accept && state == S_IDLE) begin
      case (cmd)
        CMD_UP:    choose_row <= step_dec(choose_row);
        CMD_DOWN:  choose_row <= step_inc(choose_row);
        CMD_LEFT:  choose_col <= step_dec(choose_col);
        CMD_RIGHT: choose_col <= step_inc(choose_col);
        CMD_PLACE: if (start_scan) begin
                     if (turn) display_white[cell_idx] <= 1'b1;
                     else      display_black[cell_idx] <= 1'b1;
                     org_row  <= choose_row;
                     org_col  <= choose_col;
                     move_cnt <= move_cnt + MW'(1);
                   end
        default: ;
      endcase
    end else if (scan_done) begin
      // A win keeps the mover's turn; a draw needs the full board and no win.
      if (scan_win) begin
        winner    <= turn ? WINNER_WHITE : WINNER_BLACK;
        game_over <= 1'b1;
      end else if (board_full) begin
        winner    <= WINNER_DRAW;
        game_over <= 1'b1;
      end else begin
        turn <= ~turn;
      end
    end
  end

  gobang_win_scan #(
    .N   (N),
    .WIN (WIN),
    .RW  (RW)
  ) u_scan (
    .clk         (clk),
    .rst         (rst),
    .start       (start_scan),
    .en          (busy),
    .org_row     (org_row),
    .org_col     (org_col),
    .color       (turn),
    .board_black (display_black),
    .board_white (display_white),
    .done        (scan_done),
    .win         (scan_win)
  );

endmodule

// File: tb/tb_gobang_board_ctrl.sv
// Self-checking bench for gobang_board_ctrl: directed game scenarios plus a
// random command stream compared against a board-level reference model.
module tb_gobang_board_ctrl;
  import gobang_pkg::*;

  localparam int N   = 15;
  localparam int WIN = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int n_checks = 0;
  int n_fail   = 0;

  // Main instance: N=15, WIN=5, WRAP=1
  logic m_valid, m_ready, m_turn, m_busy, m_over;
  logic [2:0] m_cmd;
  logic [N*N-1:0] m_black, m_white;
  logic [3:0] m_row, m_col;
  logic [1:0] m_winner;
  // Saturating instance: WRAP=0
  logic s_valid, s_ready, s_turn, s_busy, s_over;
  logic [2:0] s_cmd;
  logic [N*N-1:0] s_black, s_white;
  logic [3:0] s_row, s_col;
  logic [1:0] s_winner;
  // Tiny instance: N=3, WIN=3
  logic t_valid, t_ready, t_turn, t_busy, t_over;
  logic [2:0] t_cmd;
  logic [8:0] t_black, t_white;
  logic [1:0] t_row, t_col;
  logic [1:0] t_winner;

  gobang_board_ctrl #(.N(15), .WIN(5), .WRAP(1)) u_main (
    .clk(clk), .rst(rst), .cmd_valid(m_valid), .cmd(m_cmd), .cmd_ready(m_ready),
    .display_black(m_black), .display_white(m_white), .choose_row(m_row),
    .choose_col(m_col), .turn(m_turn), .busy(m_busy), .game_over(m_over),
    .winner(m_winner));

  gobang_board_ctrl #(.N(15), .WIN(5), .WRAP(0)) u_sat (
    .clk(clk), .rst(rst), .cmd_valid(s_valid), .cmd(s_cmd), .cmd_ready(s_ready),
    .display_black(s_black), .display_white(s_white), .choose_row(s_row),
    .choose_col(s_col), .turn(s_turn), .busy(s_busy), .game_over(s_over),
    .winner(s_winner));

  gobang_board_ctrl #(.N(3), .WIN(3), .WRAP(1)) u_tiny (
    .clk(clk), .rst(rst), .cmd_valid(t_valid), .cmd(t_cmd), .cmd_ready(t_ready),
    .display_black(t_black), .display_white(t_white), .choose_row(t_row),
    .choose_col(t_col), .turn(t_turn), .busy(t_busy), .game_over(t_over),
    .winner(t_winner));

  // Reference model of the main instance: 0 empty, 1 black, 2 white
  int brd [N][N];
  int e_r, e_c, e_turn, e_over, e_winner, e_moves;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    foreach (brd[r, c]) brd[r][c] = 0;
    e_r = N / 2; e_c = N / 2;
    e_turn = 0; e_over = 0; e_winner = 0; e_moves = 0;
  endfunction

  function automatic int stone(int r, int c);
    return (r >= 0 && r < N && c >= 0 && c < N) ? brd[r][c] : 0;
  endfunction

  function automatic logic [N*N-1:0] exp_board(int color);
    logic [N*N-1:0] v = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        if (brd[r][c] == color) v[r*N+c] = 1'b1;
    return v;
  endfunction

  // Counts probes and detects a win from the placed stone at the cursor.
  task automatic model_scan(output int probes, output bit won);
    int dr [4] = '{0, 1, 1, 1};
    int dc [4] = '{1, 0, 1, -1};
    int color = e_turn + 1;
    probes = 0; won = 0;
    for (int d = 0; d < 4; d++) begin
      int line = 1;
      for (int leg = 0; leg < 2; leg++) begin
        int s = (leg == 0) ? 1 : -1;
        for (int k = 1; k < WIN; k++) begin
          probes++;
          if (stone(e_r + s*k*dr[d], e_c + s*k*dc[d]) != color) break;
          line++;
          if (line >= WIN) begin won = 1; return; end
        end
      end
    end
  endtask

  task automatic model_apply(input int c, output int probes);
    bit won;
    probes = 0;
    if (c == CMD_RESTART) begin model_reset(); return; end
    if (e_over != 0) return;
    case (c)
      CMD_UP:    e_r = (e_r == 0) ? N - 1 : e_r - 1;
      CMD_DOWN:  e_r = (e_r == N - 1) ? 0 : e_r + 1;
      CMD_LEFT:  e_c = (e_c == 0) ? N - 1 : e_c - 1;
      CMD_RIGHT: e_c = (e_c == N - 1) ? 0 : e_c + 1;
      CMD_PLACE: if (brd[e_r][e_c] == 0) begin
                   brd[e_r][e_c] = e_turn + 1;
                   e_moves++;
                   model_scan(probes, won);
                   if (won) begin e_winner = e_turn + 1; e_over = 1; end
                   else if (e_moves == N*N) begin e_winner = 3; e_over = 1; end
                   else e_turn ^= 1;
                 end
      default: ;
    endcase
  endtask

  function automatic logic busy_of(int sel);
    case (sel)
      0:       return m_busy;
      1:       return s_busy;
      default: return t_busy;
    endcase
  endfunction

  function automatic logic ready_of(int sel);
    case (sel)
      0:       return m_ready;
      1:       return s_ready;
      default: return t_ready;
    endcase
  endfunction

  // One-cycle command pulse, then waits (bounded) for the win check to end.
  task automatic send(input int sel, input int c, output int cyc);
    @(negedge clk);
    check("cmd_ready", ready_of(sel), 1);
    case (sel)
      0:       begin m_valid = 1'b1; m_cmd = 3'(c); end
      1:       begin s_valid = 1'b1; s_cmd = 3'(c); end
      default: begin t_valid = 1'b1; t_cmd = 3'(c); end
    endcase
    @(negedge clk);
    m_valid = 1'b0; s_valid = 1'b0; t_valid = 1'b0;
    cyc = 0;
    while (busy_of(sel) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("busy_end", busy_of(sel), 0);
  endtask

  task automatic check_main(input string w);
    check({w, ".row"},    m_row,    e_r);
    check({w, ".col"},    m_col,    e_c);
    check({w, ".turn"},   m_turn,   e_turn);
    check({w, ".busy"},   m_busy,   0);
    check({w, ".over"},   m_over,   e_over);
    check({w, ".winner"}, m_winner, e_winner);
    check({w, ".ready"},  m_ready,  1);
    check({w, ".black"},  m_black,  exp_board(1));
    check({w, ".white"},  m_white,  exp_board(2));
  endtask

  task automatic do_cmd(input int c);
    int p, cyc;
    model_apply(c, p);
    send(0, c, cyc);
    check("busy_cycles", cyc, p);
    check_main("main");
  endtask

  task automatic goto_cell(input int r, input int c);
    while (e_r != r) do_cmd(e_r > r ? CMD_UP : CMD_DOWN);
    while (e_c != c) do_cmd(e_c > c ? CMD_LEFT : CMD_RIGHT);
  endtask

  task automatic place_at(input int r, input int c);
    goto_cell(r, c);
    do_cmd(CMD_PLACE);
  endtask

  int tr = 1, tc = 1;
  task automatic tiny_goto(input int r, input int c);
    int cyc;
    while (tr != r) begin
      send(2, tr > r ? CMD_UP : CMD_DOWN, cyc);
      tr = (tr > r) ? tr - 1 : tr + 1;
      check("tiny_row", t_row, tr);
    end
    while (tc != c) begin
      send(2, tc > c ? CMD_LEFT : CMD_RIGHT, cyc);
      tc = (tc > c) ? tc - 1 : tc + 1;
      check("tiny_col", t_col, tc);
    end
  endtask

  initial begin
    int cyc;
    int trow [9] = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
    int tcol [9] = '{0, 1, 2, 1, 0, 2, 1, 0, 2};
    m_valid = 0; s_valid = 0; t_valid = 0;
    m_cmd = 0; s_cmd = 0; t_cmd = 0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check_main("reset");
    check("tiny_rst_row", t_row, 1);
    check("tiny_rst_col", t_col, 1);
    check("sat_rst_row", s_row, 7);
    rst = 1'b0;
    @(negedge clk);
    check_main("post_reset");

    // Cursor walk with wrap, then with saturation
    for (int i = 0; i < 8; i++) do_cmd(CMD_UP);
    check("wrap_row", m_row, 14);
    for (int i = 0; i < 9; i++) begin
      send(1, CMD_UP, cyc);
      check("sat_row", s_row, (i < 7) ? 6 - i : 0);
    end
    for (int i = 0; i < 9; i++) begin
      send(1, CMD_RIGHT, cyc);
      check("sat_col", s_col, (8 + i > 14) ? 14 : 8 + i);
    end

    // First stone at centre, then a repeat on the occupied cell
    place_at(7, 7);
    check("bit112", m_black[112], 1);
    check("turn_after_first", m_turn, 1);
    do_cmd(CMD_PLACE);
    check("turn_after_dup", m_turn, 1);

    // Horizontal black win
    do_cmd(CMD_RESTART);
    place_at(7, 3); place_at(0, 0);
    place_at(7, 4); place_at(0, 2);
    place_at(7, 5); place_at(0, 4);
    place_at(7, 6); place_at(0, 6);
    place_at(7, 7);
    check("hwin_winner", m_winner, 2'b01);
    check("hwin_over", m_over, 1);
    check("hwin_turn", m_turn, 0);
    do_cmd(CMD_RIGHT);
    do_cmd(CMD_PLACE);
    check("end_black", m_black[113], 0);

    // Anti-diagonal completed from the middle
    do_cmd(CMD_RESTART);
    place_at(10, 4); place_at(0, 0);
    place_at(9, 5);  place_at(0, 2);
    place_at(7, 7);  place_at(0, 4);
    place_at(6, 8);  place_at(0, 6);
    place_at(8, 6);
    check("dwin_winner", m_winner, 2'b01);
    check("dwin_over", m_over, 1);

    // 3x3 board filled with no line: draw on the ninth stone
    for (int i = 0; i < 9; i++) begin
      tiny_goto(trow[i], tcol[i]);
      send(2, CMD_PLACE, cyc);
      if (i < 8) begin
        check("tiny_winner", t_winner, 0);
        check("tiny_over", t_over, 0);
        check("tiny_turn", t_turn, (i + 1) % 2);
      end else begin
        check("tiny_draw", t_winner, 2'b11);
        check("tiny_over_end", t_over, 1);
        check("tiny_turn_end", t_turn, 0);
        check("tiny_black", t_black, 9'h18D);
        check("tiny_white", t_white, 9'h072);
      end
    end

    // Asynchronous reset in the middle of a win check
    do_cmd(CMD_RESTART);
    @(negedge clk);
    check("pre_rst_ready", m_ready, 1);
    m_valid = 1'b1; m_cmd = 3'(CMD_PLACE);
    @(negedge clk);
    m_valid = 1'b0;
    check("mid_busy", m_busy, 1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 model_reset();
    check_main("rst_async");
    @(negedge clk);
    rst = 1'b0;
    check_main("rst_release");
    do_cmd(CMD_PLACE);
    check("new_game_bit112", m_black[112], 1);
    check("new_game_turn", m_turn, 1);

    // Random command stream against the model
    do_cmd(CMD_RESTART);
    for (int i = 0; i < 300; i++) begin
      int x = $urandom_range(0, 99);
      int c;
      if (x < 60)      c = $urandom_range(0, 3);
      else if (x < 94) c = CMD_PLACE;
      else if (x < 98) c = $urandom_range(6, 7);
      else             c = CMD_RESTART;
      if (e_over != 0 && $urandom_range(0, 3) == 0) c = CMD_RESTART;
      do_cmd(c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
